// File: rtl/ext_align_pipe_pkg.sv
// Shared types for the extract/extend pipeline: access-size encodings, the result record
// and the alignment rule used by both the pipe and the immediate path.
package ext_align_pipe_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE      = 2'd0,
      SZ_HALF      = 2'd1,
      SZ_WORD      = 2'd2,
      SZ_WORD_RSVD = 2'd3
   } size_e;

   localparam int unsigned DataWDef = 32;

   // Result record at the default width; wider instances build the same layout locally.
   typedef struct packed {
      logic [DataWDef-1:0] data;
      logic                misalign;
   } ext_res_t;

   function automatic logic is_misaligned(size_e size, logic [1:0] off_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off_lo[0];
         default: return off_lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/ext_align_pipe_if.sv
// Valid/ready bus between a producer of raw words and the extract/extend pipe.
interface ext_align_pipe_if #(
   parameter int unsigned DATA_W = 32
) ();
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [OFF_W-1:0]  in_offset;
   logic [1:0]        in_size;
   logic              in_sign;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_misalign;

   modport master (
      output flush, in_valid, in_data, in_offset, in_size, in_sign, out_ready,
      input  in_ready, out_valid, out_data, out_misalign
   );

   modport slave (
      input  flush, in_valid, in_data, in_offset, in_size, in_sign, out_ready,
      output in_ready, out_valid, out_data, out_misalign
   );
endinterface

// File: rtl/ext_align_comb.sv
// Pure field extraction plus sign/zero extension; also used by the immediate path
// with offset 0 and half size.
module ext_align_comb
   import ext_align_pipe_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [OFF_W-1:0]  offset_i,
   input  size_e             size_i,
   input  logic              sign_i,
   output logic [DATA_W-1:0] data_o,
   output logic              misalign_o
);
   localparam int unsigned IdxW  = $clog2(DATA_W) + 1;
   localparam int unsigned WordW = (DATA_W < 32) ? DATA_W : 32;

   logic [OFF_W+1:0]  off_x;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] keep;
   logic [DATA_W-1:0] ext;
   logic [IdxW-1:0]   fw;
   logic              msb;
   logic              mis;

   always_comb begin
      off_x   = {2'b00, offset_i};
      shifted = data_i >> {offset_i, 3'b000};
      case (size_i)
         SZ_BYTE: fw = IdxW'(8);
         SZ_HALF: fw = IdxW'(16);
         default: fw = IdxW'(WordW);
      endcase
      // A full-width field shifts every one out, so keep is all ones and sign has no effect.
      keep       = ~({DATA_W{1'b1}} << fw);
      msb        = |(shifted & (keep ^ (keep >> 1)));
      ext        = (shifted & keep) | ({DATA_W{sign_i & msb}} & ~keep);
      mis        = is_misaligned(size_i, off_x[1:0]);
      data_o     = mis ? '0 : ext;
      misalign_o = mis;
   end
endmodule

// File: rtl/ext_align_pipe.sv
// Registered extract/extend stage with a main output register and one skid entry,
// so in_ready comes straight from a flop.
module ext_align_pipe
   import ext_align_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   ext_align_pipe_if.slave bus
);
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              misalign;
   } res_t;

   res_t              main_q, main_d, skid_q, skid_d, ext_res;
   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              in_xfer, out_xfer;
   logic [DATA_W-1:0] ext_data;
   logic              ext_mis;

   ext_align_comb #(
      .DATA_W (DATA_W)
   ) u_comb (
      .data_i     (bus.in_data),
      .offset_i   (bus.in_offset),
      .size_i     (size_e'(bus.in_size)),
      .sign_i     (bus.in_sign),
      .data_o     (ext_data),
      .misalign_o (ext_mis)
   );

   always_comb begin
      ext_res  = '{data: ext_data, misalign: ext_mis};
      in_xfer  = bus.in_valid & ~skid_valid_q;
      out_xfer = main_valid_q & bus.out_ready;
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_xfer) begin
         // Skid full implies in_ready low, so it never races a new acceptance.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            main_d       = ext_res;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = ext_res;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.in_ready     = ~skid_valid_q;
   assign bus.out_valid    = main_valid_q;
   assign bus.out_data     = main_q.data;
   assign bus.out_misalign = main_q.misalign;
endmodule

// File: tb/tb_ext_align_pipe.sv
// Directed plus random checks of ext_align_pipe against an arithmetic reference model
// and a FIFO scoreboard of accepted entries.
module tb_ext_align_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   ext_align_pipe_if #(.DATA_W(32)) bus ();
   ext_align_pipe_if #(.DATA_W(64)) bus64 ();

   ext_align_pipe #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ext_align_pipe #(.DATA_W(64)) dut64 (
      .clk (clk),
      .rst (rst),
      .bus (bus64)
   );

   // Reference: {misalign, data} from plain arithmetic on the field value.
   function automatic logic [32:0] model(logic [31:0] d, int off, int sz, bit sg);
      int w;
      longint unsigned f;
      w = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
      if (off % (w / 8) != 0) return {1'b1, 32'h0};
      f = d;
      f = (f >> (8 * off)) % (64'd1 << w);
      if (sg && f >= (64'd1 << (w - 1))) f = f + (64'd1 << 32) - (64'd1 << w);
      return {1'b0, 32'(f)};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(bit v, logic [31:0] d, int off, int sz, bit sg);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_offset = 2'(off);
      bus.in_size   = 2'(sz);
      bus.in_sign   = sg;
   endtask

   task automatic tick();
      logic acc, xfr;
      logic [32:0] e;
      acc = bus.in_valid && bus.in_ready;
      xfr = bus.out_valid && bus.out_ready;
      if (xfr) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", bus.out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("xfer_data", bus.out_data, e[31:0]);
            chk("xfer_mis", bus.out_misalign, e[32]);
         end
      end
      if (acc) exp_q.push_back(model(bus.in_data, int'(bus.in_offset), int'(bus.in_size),
                                     bus.in_sign));
      if (bus.flush) exp_q.delete();
      @(posedge clk);
      #1;
      chk("out_valid", bus.out_valid, exp_q.size() > 0);
      chk("in_ready", bus.in_ready, exp_q.size() < 2);
   endtask

   initial begin
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(0, 32'h0, 0, 0, 0);
      bus64.flush = 1'b0;
      bus64.out_ready = 1'b1;
      bus64.in_valid = 1'b0;
      bus64.in_data = '0;
      bus64.in_offset = '0;
      bus64.in_size = 2'd0;
      bus64.in_sign = 1'b0;

      #2;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, 32'h0);
      chk("rst_out_mis", bus.out_misalign, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1'b1);

      // Byte sign/zero, half alignment.
      bus.out_ready = 1'b1;
      drive(1, 32'h1234_80FF, 1, 0, 1); tick();
      chk("byte_sx", bus.out_data, 32'hFFFF_FF80);
      chk("byte_sx_mis", bus.out_misalign, 1'b0);
      drive(1, 32'h1234_80FF, 1, 0, 0); tick();
      chk("byte_zx", bus.out_data, 32'h0000_0080);
      drive(1, 32'h8001_7FFE, 2, 1, 1); tick();
      chk("half_off2", bus.out_data, 32'hFFFF_8001);
      drive(1, 32'h8001_7FFE, 0, 1, 1); tick();
      chk("half_off0", bus.out_data, 32'h0000_7FFE);
      drive(1, 32'h8001_7FFE, 1, 1, 1); tick();
      chk("half_mis_data", bus.out_data, 32'h0);
      chk("half_mis_flag", bus.out_misalign, 1'b1);
      drive(0, 32'h0, 0, 0, 0); tick();

      // Backpressure: three offered, two taken, drain in order.
      bus.out_ready = 1'b0;
      drive(1, 32'h0000_00A1, 0, 0, 0); tick();
      drive(1, 32'h0000_00B2, 0, 0, 0); tick();
      chk("bp_in_ready_c2", bus.in_ready, 1'b0);
      drive(1, 32'h0000_00C3, 0, 0, 0); tick();
      chk("bp_hold_head", bus.out_data, 32'h0000_00A1);
      bus.out_ready = 1'b1;
      tick();
      tick();
      drive(0, 32'h0, 0, 0, 0); tick();
      tick();

      // Streaming.
      for (int i = 0; i < 100; i++) begin
         drive(1, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         tick();
      end
      drive(0, 32'h0, 0, 0, 0); tick();

      // Random valid/ready.
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
         bus.out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      bus.out_ready = 1'b1;
      drive(0, 32'h0, 0, 0, 0); tick(); tick(); tick();

      // Flush with both entries full, then flush swallowing an accepted entry.
      bus.out_ready = 1'b0;
      drive(1, 32'h0000_0011, 0, 0, 0); tick();
      drive(1, 32'h0000_0022, 0, 0, 0); tick();
      bus.flush = 1'b1;
      drive(1, 32'h0000_0033, 0, 0, 0); tick();
      bus.flush = 1'b0;
      chk("flush_out_valid", bus.out_valid, 1'b0);
      chk("flush_in_ready", bus.in_ready, 1'b1);
      drive(1, 32'h0000_0044, 0, 0, 0); tick();
      bus.flush = 1'b1;
      drive(1, 32'h0000_0055, 0, 0, 0); tick();
      bus.flush = 1'b0;
      drive(0, 32'h0, 0, 0, 0); tick();

      // Async reset mid-cycle with both entries full.
      drive(1, 32'h0000_0066, 0, 0, 0); tick();
      drive(1, 32'h0000_0077, 0, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", bus.out_valid, 1'b0);
      chk("arst_in_ready", bus.in_ready, 1'b1);
      chk("arst_out_data", bus.out_data, 32'h0);
      chk("arst_out_mis", bus.out_misalign, 1'b0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      // 64-bit datapath.
      bus64.in_valid = 1'b1;
      bus64.in_data = 64'h8000_0000_1234_5678;
      bus64.in_offset = 3'd4;
      bus64.in_size = 2'd2;
      bus64.in_sign = 1'b1;
      @(posedge clk); #1;
      chk("w64_valid", bus64.out_valid, 1'b1);
      chk("w64_word_sx", bus64.out_data, 64'hFFFF_FFFF_8000_0000);
      chk("w64_word_mis", bus64.out_misalign, 1'b0);
      bus64.in_sign = 1'b0;
      @(posedge clk); #1;
      chk("w64_word_zx", bus64.out_data, 64'h0000_0000_8000_0000);
      bus64.in_offset = 3'd2;
      @(posedge clk); #1;
      chk("w64_word_mis_data", bus64.out_data, 64'h0);
      chk("w64_word_mis_flag", bus64.out_misalign, 1'b1);
      bus64.in_offset = 3'd7;
      bus64.in_size = 2'd0;
      bus64.in_sign = 1'b1;
      @(posedge clk); #1;
      chk("w64_byte7_sx", bus64.out_data, 64'hFFFF_FFFF_FFFF_FF80);
      bus64.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("w64_drain", bus64.out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
